demux1to16_tdm: RTL and testbench

DEMUX1TO16_TDM -- requirements
Module: demux1to16_tdm

---
 rtl/demux1to16_tdm_pkg.sv | 12 +
 rtl/demux1to16_tdm_demux1to4.sv | 20 ++
 rtl/demux1to16_tdm.sv | 111 +++++++++++
 tb/tb_demux1to16_tdm.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/demux1to16_tdm_pkg.sv
// Shared constants and FSM state type for the 1:16 TDM demultiplexer.
// Imported by the top and the decoder sub-module.
package demux1to16_tdm_pkg;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;
endpackage

// File: rtl/demux1to16_tdm_demux1to4.sv
// Combinational 1:4 demultiplexer of an enable.
// Ports: i_en enable in, i_sel 2-bit select, o_y one-hot enables out.
module demux1to4 (
  input  logic       i_en,
  input  logic [1:0] i_sel,
  output logic [3:0] o_y
);
  always_comb begin
    o_y = 4'b0000;
    if (i_en) begin
      unique case (i_sel)
        2'd0: o_y = 4'b0001;
        2'd1: o_y = 4'b0010;
        2'd2: o_y = 4'b0100;
        2'd3: o_y = 4'b1000;
        default: o_y = 4'b0000;
      endcase
    end
  end
endmodule

// File: rtl/demux1to16_tdm.sv
// Serial-to-16-lane TDM frame demultiplexer with start/abort control.
// Ports: clk, rst (sync, high), start, din, din_valid in;
//   y frame, ch next channel, busy, frame_done, abort out.
module demux1to16_tdm
  import demux1to16_tdm_pkg::*;
#(
  parameter bit REVERSE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  din,
  input  logic                  din_valid,
  output logic [NUM_CH-1:0]     y,
  output logic [SEL_W-1:0]      ch,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  abort
);
  localparam logic [SEL_W-1:0] CH_LAST =
    SEL_W'(NUM_CH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_ch;
  logic [SEL_W-1:0]  w_lane;
  logic [NUM_CH-1:0] r_shadow;
  logic [NUM_CH-1:0] r_y;
  logic [NUM_CH-1:0] w_we;
  logic [NUM_CH-1:0] w_shadow_wr;
  logic [3:0]        w_l1;
  logic              r_done;
  logic              r_abort;
  logic              w_acc;
  logic              w_last;
  logic              w_restart;
  logic              w_done_nxt;
  logic              w_abort_nxt;

  // start inside COLLECT wins over any beat in the same cycle
  assign w_restart = (r_state == COLLECT) && start;
  assign w_acc     = (r_state == COLLECT) && din_valid && !start;
  assign w_last    = w_acc && (r_ch == CH_LAST);

  // 15-ch is the bitwise inverse of a 4-bit ch
  assign w_lane = REVERSE ? ~r_ch : r_ch;

  demux1to4 u_l1 (
    .i_en  (w_acc),
    .i_sel (w_lane[3:2]),
    .o_y   (w_l1)
  );

  for (genvar g = 0; g < 4; g++) begin : g_l2
    demux1to4 u_l2 (
      .i_en  (w_l1[g]),
      .i_sel (w_lane[1:0]),
      .o_y   (w_we[4*g +: 4])
    );
  end

  assign w_shadow_wr =
    (r_shadow & ~w_we) | (w_we & {NUM_CH{din}});

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = COLLECT;
      COLLECT: if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? COLLECT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_done_nxt  = w_last;
    w_abort_nxt = w_restart;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ch     <= '0;
      r_shadow <= '0;
      r_y      <= '0;
      r_done   <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_done  <= w_done_nxt;
      r_abort <= w_abort_nxt;
      if (start) begin
        r_ch     <= '0;
        r_shadow <= '0;
      end else if (w_acc) begin
        r_ch     <= r_ch + 1'b1;
        r_shadow <= w_shadow_wr;
        if (w_last) r_y <= w_shadow_wr;
      end
    end
  end

  assign y          = r_y;
  assign ch         = r_ch;
  assign busy       = (r_state == COLLECT);
  assign frame_done = r_done;
  assign abort      = r_abort;
endmodule

// File: tb/tb_demux1to16_tdm.sv
// Scoreboard bench for demux1to16_tdm, both lane orders.
// Directed frames, gaps, restarts, back-to-back and reset.
module tb_demux1to16_tdm;
  logic        clk = 1'b0;
  logic        rst, start, din, din_valid;
  logic [15:0] y0, y1;
  logic [3:0]  ch0, ch1;
  logic        busy0, busy1, fd0, fd1, ab0, ab1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int nab0  = 0;
  int nab1  = 0;
  int a0, a1;

  typedef struct {
    logic [15:0] y;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  always #5 clk = ~clk;

  demux1to16_tdm #(.REVERSE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
    .din(din), .din_valid(din_valid),
    .y(y0), .ch(ch0), .busy(busy0),
    .frame_done(fd0), .abort(ab0)
  );

  demux1to16_tdm #(.REVERSE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start),
    .din(din), .din_valid(din_valid),
    .y(y1), .ch(ch1), .busy(busy1),
    .frame_done(fd1), .abort(ab1)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ab0) nab0++;
    if (ab1) nab1++;
    if (fd0) begin
      total++;
      if (q0.size() == 0) begin
        bad++;
        $display("FAIL done0 unexpected y=%h", y0);
      end else begin
        e0 = q0.pop_front();
        if (y0 !== e0.y || cyc != e0.c) begin
          bad++;
          $display("FAIL done0 y=%h cyc=%0d want y=%h cyc=%0d",
                   y0, cyc, e0.y, e0.c);
        end
      end
    end
    if (fd1) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL done1 unexpected y=%h", y1);
      end else begin
        e1 = q1.pop_front();
        if (y1 !== e1.y || cyc != e1.c) begin
          bad++;
          $display("FAIL done1 y=%h cyc=%0d want y=%h cyc=%0d",
                   y1, cyc, e1.y, e1.c);
        end
      end
    end
  end

  task automatic chk(input string n,
                     input logic [15:0] a,
                     input logic [15:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, x);
    end
  endtask

  task automatic beat(input logic s, input logic d,
                      input logic v, input logic r = 1'b0);
    @(negedge clk);
    rst = r; start = s; din = d; din_valid = v;
    @(posedge clk);
    #1;
  endtask

  // expected frames: hand-computed for both lane orders
  task automatic push(input logic [15:0] w0,
                      input logic [15:0] w1);
    q0.push_back('{y: w0, c: cyc + 1});
    q1.push_back('{y: w1, c: cyc + 1});
  endtask

  task automatic send(input logic [15:0] w,
                      input logic [15:0] w1);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) push(w, w1);
      beat(1'b0, w[k], 1'b1);
    end
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; start = 1'b0;
    din = 1'b0; din_valid = 1'b0;
    beat(1'b0, 1'b0, 1'b0, 1'b1);
    beat(1'b1, 1'b1, 1'b1, 1'b1);
    chk("rst_y0", y0, 16'h0000);
    chk("rst_y1", y1, 16'h0000);
    chk("rst_ch", 16'(ch0), 16'd0);
    chk("rst_busy", 16'(busy0), 16'd0);
    chk("rst_done", 16'(fd0), 16'd0);
    chk("rst_abort", 16'(ab0), 16'd0);

    // frame 0xA5C3, din ignored in the start cycle
    beat(1'b1, 1'b1, 1'b1);
    chk("start_busy", 16'(busy0), 16'd1);
    chk("start_ch", 16'(ch0), 16'd0);
    send(16'hA5C3, 16'hC3A5);
    chk("a5_y0", y0, 16'hA5C3);
    chk("a5_y1", y1, 16'hC3A5);
    chk("a5_done", 16'(fd0), 16'd1);
    chk("a5_busy", 16'(busy0), 16'd0);
    beat(1'b0, 1'b0, 1'b0);
    chk("idle_done", 16'(fd0), 16'd0);
    chk("idle_ch", 16'(ch1), 16'd0);

    // valid toggling every cycle
    beat(1'b1, 1'b0, 1'b0);
    w = 16'h5A3C;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        if (i == 30) push(16'h5A3C, 16'h3C5A);
        beat(1'b0, w[i/2], 1'b1);
      end else begin
        beat(1'b0, 1'b1, 1'b0);
      end
      if (i == 7) begin
        chk("gap_ch0", 16'(ch0), 16'd4);
        chk("gap_ch1", 16'(ch1), 16'd4);
      end
      if (i == 29) chk("hold_y0", y0, 16'hA5C3);
    end
    chk("tog_y0", y0, 16'h5A3C);
    chk("tog_y1", y1, 16'h3C5A);

    // restart after 7 beats
    a0 = nab0; a1 = nab1;
    beat(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) beat(1'b0, 1'b1, 1'b1);
    chk("pre_ch", 16'(ch0), 16'd7);
    beat(1'b1, 1'b1, 1'b1);
    chk("rs_ch", 16'(ch0), 16'd0);
    chk("rs_busy", 16'(busy0), 16'd1);
    chk("rs_abort", 16'(ab0), 16'd1);
    send(16'hFFFF, 16'hFFFF);
    chk("ab_cnt0", 16'(nab0 - a0), 16'd1);
    chk("ab_cnt1", 16'(nab1 - a1), 16'd1);
    chk("ff_y0", y0, 16'hFFFF);

    // start in DONE: back-to-back frame
    beat(1'b1, 1'b0, 1'b0);
    chk("b2b_busy", 16'(busy0), 16'd1);
    chk("b2b_ch", 16'(ch0), 16'd0);
    chk("b2b_hold", y0, 16'hFFFF);
    send(16'h0001, 16'h8000);
    chk("one_y0", y0, 16'h0001);
    chk("one_y1", y1, 16'h8000);

    // restart coincident with the 16th beat
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) beat(1'b0, 1'b1, 1'b1);
    chk("c15_ch", 16'(ch0), 16'd15);
    beat(1'b1, 1'b0, 1'b1);
    chk("c15_y0", y0, 16'h0001);
    chk("c15_y1", y1, 16'h8000);
    chk("c15_done", 16'(fd1), 16'd0);
    chk("c15_abort", 16'(ab1), 16'd1);
    chk("c15_ch0", 16'(ch0), 16'd0);
    send(16'h0F0F, 16'hF0F0);
    chk("0f_y1", y1, 16'hF0F0);

    // reset mid-frame
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    a0 = nab0; a1 = nab1;
    for (int i = 0; i < 10; i++) beat(1'b0, 1'b1, 1'b1);
    beat(1'b0, 1'b1, 1'b1, 1'b1);
    chk("mr_y0", y0, 16'h0000);
    chk("mr_y1", y1, 16'h0000);
    chk("mr_ch", 16'(ch0), 16'd0);
    chk("mr_busy", 16'(busy0), 16'd0);
    chk("mr_done", 16'(fd0), 16'd0);
    chk("mr_abort", 16'(ab0), 16'd0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    chk("mr_ab0", 16'(nab0 - a0), 16'd0);
    chk("mr_ab1", 16'(nab1 - a1), 16'd0);
    chk("q0_empty", 16'(q0.size()), 16'd0);
    chk("q1_empty", 16'(q1.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
